// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: groups the receiver, transmitter and register-bus signals
// of the serial command controller.
//   master : the command controller itself
//   slave  : the environment (UART rx/tx and the register block)
interface uart_cmd_ctrl_if;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       tx_done_tick;
  logic       wr_en;
  logic       rd_en;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy;
  logic       err_tick;

  modport master (
    input  rx_done_tick, rx_dout, tx_done_tick, rd_data,
    output tx_start, tx_din, wr_en, rd_en, addr, wr_data, busy, err_tick
  );

  modport slave (
    output rx_done_tick, rx_dout, tx_done_tick, rd_data,
    input  tx_start, tx_din, wr_en, rd_en, addr, wr_data, busy, err_tick
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses SYNC/CMD/[DATA]/[CHK] frames from the UART receiver,
// performs a single register write or read, and answers through the UART
// transmitter with ACK (0x06), NAK (0x15) or the read data byte.
//
// Build option: define UART_CMD_CHECKSUM_EN to require a trailing checksum
// byte (CMD ^ DATA for writes, CMD for reads). Without it frames execute
// right after the last CMD/DATA byte and NAK is never produced.
//
// Every output is a register or a decode of the registered state, so nothing
// from rx_* or rd_data reaches an output combinationally.
module uart_cmd_ctrl #(
  parameter int         TIMEOUT   = 100000,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic             clk,
  input logic             reset_n,
  uart_cmd_ctrl_if.master bus
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [7:0]       ACK_BYTE  = 8'h06;

  typedef enum logic [2:0] {
    S_SYNC,
    S_CMD,
    S_DATA,
    S_CHK,
    S_EXEC,
    S_READ,
    S_TX_START,
    S_TX_WAIT
  } state_t;

  // Where a frame goes once its last address/data byte has been received.
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [7:0] NAK_BYTE     = 8'h15;
  localparam state_t     PAYLOAD_DONE = S_CHK;
`else
  localparam state_t     PAYLOAD_DONE = S_EXEC;
`endif

  state_t           state_reg, state_next;
  logic             write_reg, write_next;     // 1 = write frame, 0 = read frame
  logic [6:0]       addr_reg, addr_next;
  logic [7:0]       wr_data_reg, wr_data_next;
  logic [7:0]       tx_din_reg, tx_din_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;         // cycles since the last received byte

  logic byte_tick;
  logic in_frame;
  logic timeout_hit;
  logic overrun;

  assign byte_tick = bus.rx_done_tick;

  // Only the byte-collecting states are subject to the inter-byte timeout.
  assign in_frame = (state_reg == S_CMD) || (state_reg == S_DATA) ||
                    (state_reg == S_CHK);

  // A byte arriving on the terminal-count cycle takes priority over the timeout.
  assign timeout_hit = in_frame && !byte_tick && (cnt_reg == CNT_LIMIT);

  // Bytes that arrive while a command is executing or being answered are lost.
  assign overrun = byte_tick &&
                   ((state_reg == S_EXEC) || (state_reg == S_READ) ||
                    (state_reg == S_TX_START) || (state_reg == S_TX_WAIT));

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] cmd_byte;
  logic [7:0] chk_expected;
  assign cmd_byte     = {write_reg, addr_reg};
  assign chk_expected = write_reg ? (cmd_byte ^ wr_data_reg) : cmd_byte;
`endif

  // Inter-byte counter: restarts on every byte, saturates, parked at zero outside frames.
  always_comb begin
    cnt_next = '0;
    if (byte_tick || timeout_hit) begin
      cnt_next = '0;
    end else if (in_frame) begin
      cnt_next = (cnt_reg == CNT_LIMIT) ? cnt_reg : cnt_reg + CNT_W'(1);
    end
  end

  // Frame parser, bus sequencing and response selection.
  always_comb begin
    state_next   = state_reg;
    write_next   = write_reg;
    addr_next    = addr_reg;
    wr_data_next = wr_data_reg;
    tx_din_next  = tx_din_reg;
    err_next     = overrun;

    if (timeout_hit) begin
      // Abandon the partial frame silently apart from the error pulse.
      err_next   = 1'b1;
      state_next = S_SYNC;
    end else begin
      case (state_reg)
        S_SYNC: begin
          if (byte_tick && (bus.rx_dout == SYNC_BYTE)) begin
            state_next = S_CMD;
          end
        end

        S_CMD: begin
          if (byte_tick) begin
            write_next = bus.rx_dout[7];
            addr_next  = bus.rx_dout[6:0];
            state_next = bus.rx_dout[7] ? S_DATA : PAYLOAD_DONE;
          end
        end

        S_DATA: begin
          if (byte_tick) begin
            wr_data_next = bus.rx_dout;
            state_next   = PAYLOAD_DONE;
          end
        end

        S_CHK: begin
`ifdef UART_CMD_CHECKSUM_EN
          if (byte_tick) begin
            if (bus.rx_dout == chk_expected) begin
              state_next = S_EXEC;
            end else begin
              // Corrupt frame: answer NAK without touching the register bus.
              err_next    = 1'b1;
              tx_din_next = NAK_BYTE;
              state_next  = S_TX_START;
            end
          end
`else
          state_next = S_SYNC;
`endif
        end

        S_EXEC: begin
          if (write_reg) begin
            tx_din_next = ACK_BYTE;
            state_next  = S_TX_START;
          end else begin
            state_next = S_READ;
          end
        end

        S_READ: begin
          // Register data is valid the cycle after the read strobe.
          tx_din_next = bus.rd_data;
          state_next  = S_TX_START;
        end

        S_TX_START: begin
          state_next = S_TX_WAIT;
        end

        S_TX_WAIT: begin
          if (bus.tx_done_tick) begin
            state_next = S_SYNC;
          end
        end

        default: begin
          state_next = S_SYNC;
        end
      endcase
    end
  end

  // State and datapath registers; reset aborts any frame or transmission at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_SYNC;
      write_reg   <= 1'b0;
      addr_reg    <= '0;
      wr_data_reg <= '0;
      tx_din_reg  <= '0;
      err_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      write_reg   <= write_next;
      addr_reg    <= addr_next;
      wr_data_reg <= wr_data_next;
      tx_din_reg  <= tx_din_next;
      err_reg     <= err_next;
      cnt_reg     <= cnt_next;
    end
  end

  // Strobes and status are decodes of the registered state.
  assign bus.tx_start = (state_reg == S_TX_START);
  assign bus.wr_en    = (state_reg == S_EXEC) && write_reg;
  assign bus.rd_en    = (state_reg == S_EXEC) && !write_reg;
  assign bus.busy     = (state_reg != S_SYNC);
  assign bus.err_tick = err_reg;
  assign bus.tx_din   = tx_din_reg;
  assign bus.addr     = addr_reg;
  assign bus.wr_data  = wr_data_reg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed frames against uart_cmd_ctrl with a scoreboard of
// expected bus strobes and transmit requests (kind, address, data, cycle).
module tb_uart_cmd_ctrl;

  localparam int TO   = 40;
  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_TX = 2;

  typedef struct {
    int         kind;
    logic [6:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   err_cnt = 0;
  int   last_err_cyc = -1;
  int   tx_delay = 10;
  ev_t  exp_q[$];

  logic [7:0] mem [128];
  bit         mem_valid [128];
  logic [7:0] model [128];
  bit         model_valid [128];

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(.TIMEOUT(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input logic [6:0] a);
    return (a == 7'h12) ? 8'hC3 : ({a, 1'b0} ^ 8'h96);
  endfunction

  // Register block: stores writes, returns read data the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.addr]       <= bus.wr_data;
      mem_valid[bus.addr] <= 1'b1;
    end
    bus.rd_data <= bus.rd_en ? (mem_valid[bus.addr] ? mem[bus.addr] : init_val(bus.addr)) : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take(input int kind, input string nm);
    ev_t e;
    check({nm, "_expected"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, 32'(kind), 32'(e.kind));
      check({nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
      if (kind != K_TX) check({nm, "_addr"}, 32'(bus.addr), 32'(e.addr));
      if (kind == K_WR) check("wr_data", 32'(bus.wr_data), 32'(e.data));
      if (kind == K_TX) check("tx_din", 32'(bus.tx_din), 32'(e.data));
      $display("event %s addr=%h data=%h cycle=%0d", nm, bus.addr,
               (kind == K_TX) ? bus.tx_din : bus.wr_data, cyc);
    end
  endtask

  // Monitor: samples outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.err_tick) begin
          err_cnt++;
          last_err_cyc = cyc;
        end
        if (bus.wr_en)    take(K_WR, "wr");
        if (bus.rd_en)    take(K_RD, "rd");
        if (bus.tx_start) take(K_TX, "tx");
      end
    end
  end

  // Transmitter model: reports done tx_delay cycles after each start.
  initial begin
    bus.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.tx_start) begin
        repeat (tx_delay) @(posedge clk);
        #1 bus.tx_done_tick = 1'b1;
        @(posedge clk);
        #1 bus.tx_done_tick = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, output int n);
    @(posedge clk);
    #1;
    bus.rx_dout      = b;
    bus.rx_done_tick = 1'b1;
    n = cyc;
    @(posedge clk);
    #1;
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, output int n);
    logic [7:0] cmd;
    cmd = {1'b1, a};
    send_byte(8'hA5, n);
    send_byte(cmd, n);
    send_byte(d, n);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cmd ^ d, n);
`endif
    exp_q.push_back('{kind: K_WR, addr: a, data: d, cyc: n + 1});
    exp_q.push_back('{kind: K_TX, addr: 7'h0, data: 8'h06, cyc: n + 2});
    model[a]       = d;
    model_valid[a] = 1'b1;
    $display("write frame addr=%h data=%h last_byte_cycle=%0d", a, d, n);
  endtask

  task automatic do_read(input logic [6:0] a, output int n);
    logic [7:0] cmd;
    logic [7:0] exp;
    cmd = {1'b0, a};
    exp = model_valid[a] ? model[a] : init_val(a);
    send_byte(8'hA5, n);
    send_byte(cmd, n);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cmd, n);
`endif
    exp_q.push_back('{kind: K_RD, addr: a, data: 8'h00, cyc: n + 1});
    exp_q.push_back('{kind: K_TX, addr: 7'h0, data: exp, cyc: n + 3});
    $display("read frame addr=%h expect=%h last_byte_cycle=%0d", a, exp, n);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string p);
    check({p, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({p, "_wr_en"},    32'(bus.wr_en),    32'd0);
    check({p, "_rd_en"},    32'(bus.rd_en),    32'd0);
    check({p, "_err_tick"}, 32'(bus.err_tick), 32'd0);
    check({p, "_busy"},     32'(bus.busy),     32'd0);
    check({p, "_tx_din"},   32'(bus.tx_din),   32'd0);
    check({p, "_addr"},     32'(bus.addr),     32'd0);
    check({p, "_wr_data"},  32'(bus.wr_data),  32'd0);
  endtask

  initial begin
    int n;
    int e0;
    bus.rx_done_tick = 1'b0;
    bus.rx_dout      = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic write then reads (preset value and written value)
    do_write(7'h05, 8'h3C, n);
    wait_idle("wr1");
    do_read(7'h12, n);
    wait_idle("rd1");
    do_read(7'h05, n);
    wait_idle("rd2");

    // Sync value inside a frame is plain data
    do_write(7'h25, 8'hA5, n);
    wait_idle("wr_sync_data");
    do_read(7'h25, n);
    wait_idle("rd_sync_data");

`ifdef UART_CMD_CHECKSUM_EN
    // Bad checksum: NAK, error pulse, no register access
    e0 = err_cnt;
    send_byte(8'hA5, n);
    send_byte(8'h85, n);
    send_byte(8'h5A, n);
    send_byte(8'h00, n);
    exp_q.push_back('{kind: K_TX, addr: 7'h0, data: 8'h15, cyc: n + 1});
    wait_idle("bad_chk");
    check("bad_chk_err_cnt", 32'(err_cnt), 32'(e0 + 1));
    check("bad_chk_err_cyc", 32'(last_err_cyc), 32'(n + 1));
    do_read(7'h05, n);
    wait_idle("rd_after_nak");
`endif

    // Timeout mid-frame: error, back to idle, no response
    e0 = err_cnt;
    send_byte(8'hA5, n);
    send_byte(8'h85, n);
    repeat (10) @(negedge clk);
    check("timeout_busy_during", 32'(bus.busy), 32'd1);
    while (cyc < n + TO + 4) @(negedge clk);
    check("timeout_err_cnt", 32'(err_cnt), 32'(e0 + 1));
    check("timeout_err_cyc", 32'(last_err_cyc), 32'(n + TO + 2));
    check("timeout_busy_after", 32'(bus.busy), 32'd0);
    check("timeout_q_empty", 32'(exp_q.size()), 32'd0);
    do_write(7'h05, 8'h11, n);
    wait_idle("wr_after_timeout");
    do_read(7'h05, n);
    wait_idle("rd_after_timeout");

    // Overrun while waiting for the transmitter
    e0 = err_cnt;
    do_write(7'h33, 8'h44, n);
    @(posedge clk);
    send_byte(8'h77, n);
    wait_idle("overrun");
    check("overrun_err_cnt", 32'(err_cnt), 32'(e0 + 1));
    check("overrun_err_cyc", 32'(last_err_cyc), 32'(n + 1));
    do_read(7'h33, n);
    wait_idle("rd_after_overrun");

    // Junk before the sync byte is ignored without error
    e0 = err_cnt;
    send_byte(8'h00, n);
    send_byte(8'hFF, n);
    check("junk_busy", 32'(bus.busy), 32'd0);
    do_write(7'h40, 8'h9C, n);
    wait_idle("wr_after_junk");
    check("junk_err_cnt", 32'(err_cnt), 32'(e0));

    // Reset during transmit wait
    do_write(7'h06, 8'h77, n);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_busy", 32'(bus.busy), 32'd0);
    check("post_reset_q_empty", 32'(exp_q.size()), 32'd0);
    do_read(7'h06, n);
    wait_idle("rd_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command controller sitting behind the UART receiver and in front of the UART transmitter. Consumes received bytes (`rx_done_tick`/`rx_dout`), parses fixed-format register-access frames, issues single-cycle writes or reads on a simple register bus, and sequences the transmitter to return an ACK, NAK or read data byte. It is the only master of the on-chip configuration register bus driven from the serial link.

## Interface

Parameters:

- `TIMEOUT`, 100000: maximum clk cycles allowed between bytes of one frame.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports (reset `reset_n`, asynchronous, active-low; clock `clk`):

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `rx_done_tick`  in  1  one-cycle pulse, received byte valid
- `rx_dout`  in  8  received byte
- `tx_start`  out  1  one-cycle pulse, start transmitting `tx_din`
- `tx_din`  out  8  byte to transmit, held stable until `tx_done_tick`
- `tx_done_tick`  in  1  one-cycle pulse, transmitter finished
- `wr_en`  out  1  register write strobe, one cycle
- `rd_en`  out  1  register read strobe, one cycle
- `addr`  out  7  register address
- `wr_data`  out  8  register write data
- `rd_data`  in  8  register read data, valid the cycle after `rd_en`
- `busy`  out  1  high in every state except S_SYNC
- `err_tick`  out  1  one-cycle pulse on timeout, checksum fail or overrun

## Operation

- Frame: SYNC_BYTE, CMD, [DATA if write], [CHK if `UART_CMD_CHECKSUM_EN`]. CMD[7]=1 write, 0 read; CMD[6:0]=address.
- States: S_SYNC, S_CMD, S_DATA, S_CHK, S_EXEC, S_READ, S_TX_START, S_TX_WAIT.
- S_SYNC: byte == SYNC_BYTE → S_CMD; any other byte discarded.
- S_CMD: latch `addr`, direction. Write → S_DATA. Read → S_CHK (checksum on) or S_EXEC.
- S_DATA: latch `wr_data` → S_CHK (checksum on) or S_EXEC.
- S_CHK: compare byte with expected; match → S_EXEC; mismatch → `err_tick`, `tx_din`=8'h15 (NAK), S_TX_START; no bus access.
- S_EXEC: write → `wr_en`=1, `tx_din`=8'h06 (ACK), → S_TX_START. Read → `rd_en`=1 → S_READ.
- S_READ: capture `rd_data` into `tx_din` → S_TX_START.
- S_TX_START: `tx_start`=1 one cycle → S_TX_WAIT.
- S_TX_WAIT: on `tx_done_tick` → S_SYNC.
- SYNC_BYTE value in S_CMD/S_DATA/S_CHK is ordinary data (no resync).
- Timeout: byte counter cleared on every `rx_done_tick`; in S_CMD/S_DATA/S_CHK, count reaching TIMEOUT → `err_tick`, S_SYNC, no response. Counter width $clog2(TIMEOUT+1), saturating, idle elsewhere.
- Overrun: `rx_done_tick` in S_EXEC/S_READ/S_TX_START/S_TX_WAIT → byte dropped, `err_tick` pulse, state unaffected.
- Simultaneous `rx_done_tick` and timeout terminal count: byte wins, no timeout.

## Timing

- Reset: state S_SYNC; `tx_start`, `wr_en`, `rd_en`, `err_tick`, `busy` = 0; `tx_din`, `addr`, `wr_data` = 0; timeout counter 0. Reset mid-frame or mid-transmit aborts immediately, no strobe emitted.
- All outputs registered or decoded from registered state only; no combinational path from `rx_*`/`rd_data` to outputs.
- Write: last frame byte's `rx_done_tick` in cycle N → `wr_en` cycle N+1 → `tx_start` cycle N+2.
- Read: last frame byte's `rx_done_tick` in cycle N → `rd_en` cycle N+1 → `rd_data` sampled cycle N+2 → `tx_start` cycle N+3.
- `addr`/`wr_data` stable from strobe cycle until next frame's CMD/DATA byte.
- `err_tick` on checksum fail is coincident with the S_CHK byte's cycle+1.

## Configuration

- `UART_CMD_CHECKSUM_EN` defined: CHK byte required; expected = CMD ^ DATA (write) or CMD (read); mismatch → NAK 8'h15.
- Undefined: no CHK byte, S_CHK unreachable, NAK never sent; frames execute after final CMD/DATA byte.

## Test plan

- Write A5,85,3C (no checksum) → `wr_en` one cycle with `addr`=7'h05, `wr_data`=8'h3C; `tx_start` with `tx_din`=8'h06.
- Read A5,12, `rd_data`=8'hC3 → `rd_en` with `addr`=7'h12; `tx_din`=8'hC3 at `tx_start`, exactly 3 cycles after last `rx_done_tick`.
- Checksum on: A5,85,3C,B9 → write + ACK; A5,85,3C,00 → no `wr_en`, `err_tick`, `tx_din`=8'h15.
- A5,85 then silence TIMEOUT cycles → `err_tick`, `busy`=0, no `tx_start`; next A5,85,11 executes normally.
- Byte arrives during S_TX_WAIT → `err_tick`, byte dropped, ACK completes; junk 00,FF before A5 ignored.
- `reset_n` low during S_TX_WAIT → all outputs 0, state S_SYNC, no strobe after release.
